// File: rtl/piu_dyninfo_ctrl.sv
// piu_dyninfo_ctrl: sequencer for the PIU next-source datapath (piu_nextsrc).
// Accepts one patch-op command per handshake and drives the piu_nextsrc strobes.
// Owns the pchlist/esmon/merged state registers. Streams the set-bit indices of
// the selected register, lowest first, one per accepted output beat.
// Optional feature: define PIU_CTRL_PERFCNT_EN to build the emitted-index counter.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both high
// at the rising clock edge. The producer holds valid and payload stable until
// ready is seen. in_ready is high only in IDLE. Once out_valid rises it stays
// high with a stable out_pchidx until out_ready is seen.
module piu_dyninfo_ctrl #(
  parameter  int NUM_PCHROW = 4,
  parameter  int NUM_PCHCOL = 7,
  localparam int NUM_PCH    = NUM_PCHROW * NUM_PCHCOL,
  localparam int IDXW       = $clog2(NUM_PCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_opcode,
  input  logic [NUM_PCH-1:0] in_pchlist,
  output logic [NUM_PCH-1:0] pch_list,
  output logic               take_in,
  output logic               prep_dyninfo,
  output logic               split_dyninfo,
  output logic               set_merged,
  output logic               copy_merged,
  output logic [1:0]         sel_pchidxsrc,
  output logic [NUM_PCH-1:0] next_pchidxsrc,
  output logic [NUM_PCH-1:0] merged_mem,
  input  logic [NUM_PCH-1:0] next_pchlist,
  input  logic [NUM_PCH-1:0] next_esmon,
  input  logic [NUM_PCH-1:0] next_merged,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDXW-1:0]    out_pchidx,
  output logic               done,
  output logic               err,
  output logic [31:0]        perf_cnt,
  output logic [1:0]         dbg_state,
  output logic [NUM_PCH-1:0] dbg_pchlist,
  output logic [NUM_PCH-1:0] dbg_esmon
);

  localparam logic [2:0] OP_LIST  = 3'd0;
  localparam logic [2:0] OP_PREP  = 3'd1;
  localparam logic [2:0] OP_SPLIT = 3'd2;
  localparam logic [2:0] OP_MERGE = 3'd3;
  localparam logic [2:0] OP_COPY  = 3'd4;

  // Scan source selector encoding shared with piu_nextsrc.
  localparam logic [1:0] SRC_NONE    = 2'b00;
  localparam logic [1:0] SRC_PCHLIST = 2'b01;
  localparam logic [1:0] SRC_ESMON   = 2'b10;
  localparam logic [1:0] SRC_MERGED  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAKE = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           target_q;
  logic [NUM_PCH-1:0]   pchlist_q;
  logic [NUM_PCH-1:0]   esmon_q;
  logic [NUM_PCH-1:0]   merged_q;
  logic [NUM_PCH-1:0]   scan_mask;
  logic [IDXW-1:0]      scan_idx;
  logic                 beat;

  assign in_ready    = (state == S_IDLE);
  assign merged_mem  = merged_q;
  assign dbg_state   = state;
  assign dbg_pchlist = pchlist_q;
  assign dbg_esmon   = esmon_q;
  assign beat        = out_valid & out_ready;

  // Scan datapath: pick the target register, find its lowest set bit, clear it.
  always_comb begin
    scan_mask = '0;
    if (state == S_SCAN) begin
      case (target_q)
        SRC_PCHLIST: scan_mask = pchlist_q;
        SRC_ESMON:   scan_mask = esmon_q;
        SRC_MERGED:  scan_mask = merged_q;
        default:     scan_mask = '0;
      endcase
    end
    scan_idx = '0;
    for (int i = NUM_PCH - 1; i >= 0; i--) begin
      if (scan_mask[i]) scan_idx = IDXW'(i);
    end
    next_pchidxsrc = scan_mask & ~(NUM_PCH'(1) << scan_idx);
    out_valid      = (state == S_SCAN) && (scan_mask != '0);
    out_pchidx     = scan_idx;
    sel_pchidxsrc  = (state == S_SCAN) ? target_q : SRC_NONE;
  end

  // Control FSM: state, latched command, registered strobes, done and err pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      target_q      <= SRC_NONE;
      pch_list      <= '0;
      take_in       <= 1'b0;
      prep_dyninfo  <= 1'b0;
      split_dyninfo <= 1'b0;
      set_merged    <= 1'b0;
      copy_merged   <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      take_in       <= 1'b0;
      prep_dyninfo  <= 1'b0;
      split_dyninfo <= 1'b0;
      set_merged    <= 1'b0;
      copy_merged   <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            pch_list <= in_pchlist;
            state    <= S_TAKE;
            case (in_opcode)
              OP_LIST:  begin take_in <= 1'b1; target_q <= SRC_PCHLIST; end
              OP_PREP:  begin take_in <= 1'b1; prep_dyninfo <= 1'b1; target_q <= SRC_ESMON; end
              OP_SPLIT: begin take_in <= 1'b1; split_dyninfo <= 1'b1; target_q <= SRC_ESMON; end
              OP_MERGE: begin take_in <= 1'b1; set_merged <= 1'b1; target_q <= SRC_MERGED; end
              OP_COPY:  begin copy_merged <= 1'b1; target_q <= SRC_MERGED; end
              default:  err <= 1'b1;
            endcase
          end
        end
        // An illegal command has err high in TAKE and returns straight to IDLE.
        S_TAKE: state <= err ? S_IDLE : S_SCAN;
        S_SCAN: begin
          if (scan_mask == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // State registers: load from piu_nextsrc on TAKE strobes and on each accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pchlist_q <= '0;
      esmon_q   <= '0;
      merged_q  <= '0;
    end else begin
      if (take_in) pchlist_q <= next_pchlist;
      if (prep_dyninfo || split_dyninfo || set_merged) esmon_q <= next_esmon;
      if (set_merged || copy_merged) merged_q <= next_merged;
      if (beat) begin
        case (target_q)
          SRC_PCHLIST: pchlist_q <= next_pchlist;
          SRC_ESMON:   esmon_q   <= next_esmon;
          SRC_MERGED:  merged_q  <= next_merged;
          default:     ;
        endcase
      end
    end
  end

`ifdef PIU_CTRL_PERFCNT_EN
  logic [31:0] perf_q;

  // Emitted-index counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= '0;
    else if (beat) perf_q <= perf_q + 32'd1;
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule
